mem_stage: RTL and testbench

- Memory-access pipeline stage; sits between the execute stage and the write-back stage.
- Latches the execute result bus and waits for the data-SRAM response on memory instructions.
- Sign- or zero-extends load data and forms the write-back bus (dest, final_result, gr_we).
- Provides a forwarding bus to decode and the valid/allow_in handshake on both sides.

---
 rtl/mem_stage_pkg.sv | 32 +++
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_load_ext.sv | 37 +++
 rtl/mem_stage.sv | 96 +++++++++
 tb/tb_mem_stage.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory-access stage: bus widths, the EX->MEM
// field layout, load-op codes and the response-wait state encoding.
package mem_stage_pkg;

    localparam int TO_MEM_DATA_WIDTH = 75;
    localparam int TO_WB_DATA_WIDTH  = 65;
    localparam int MEM_FWD_WIDTH     = 38;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    // Field order matches the EX->MEM bus, MSB first
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic        gr_we;
        logic        res_from_mem;
        logic [2:0]  mem_op;
        logic        mem_req;
    } to_mem_bus_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HAVE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake and data buses around the memory stage: EX side, WB side,
// data-SRAM response and the forwarding path back to decode.
interface mem_stage_if
    import mem_stage_pkg::*;
();
    logic                         EX_to_MEM_valid;
    logic [TO_MEM_DATA_WIDTH-1:0] to_MEM_data;
    logic                         MEM_allow_in;
    logic                         WB_allow_in;
    logic                         MEM_to_WB_valid;
    logic [TO_WB_DATA_WIDTH-1:0]  to_WB_data;
    logic                         data_sram_data_ok;
    logic [31:0]                  data_sram_rdata;
    logic [MEM_FWD_WIDTH-1:0]     MEM_fwd;

    modport master (
        output EX_to_MEM_valid, to_MEM_data, WB_allow_in,
        output data_sram_data_ok, data_sram_rdata,
        input  MEM_allow_in, MEM_to_WB_valid, to_WB_data, MEM_fwd
    );

    modport slave (
        input  EX_to_MEM_valid, to_MEM_data, WB_allow_in,
        input  data_sram_data_ok, data_sram_rdata,
        output MEM_allow_in, MEM_to_WB_valid, to_WB_data, MEM_fwd
    );
endinterface

// File: rtl/mem_load_ext.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
// Purely combinational so the cache refill path can reuse it.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  mem_op,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v   = rdata[7:0];
        half_v   = addr[1] ? rdata[31:16] : rdata[15:0];
        ext_data = rdata;

        case (addr)
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            2'd3:    byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase

        // Unknown op codes fall back to a plain word
        case (mem_op)
            LD_B:    ext_data = {{24{byte_v[7]}}, byte_v};
            LD_H:    ext_data = {{16{half_v[15]}}, half_v};
            LD_BU:   ext_data = {24'd0, byte_v};
            LD_HU:   ext_data = {16'd0, half_v};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds the EX result, waits for the data-SRAM
// response on memory instructions and forms the write-back and forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    mem_stage_if.slave mem_bus
);

    logic        valid_q,     valid_d;
    mem_state_e  state_q,     state_d;
    to_mem_bus_t bus_q,       bus_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    to_mem_bus_t in_bus;
    logic        data_ok;
    logic        ready_go;
    logic        allow_in;
    logic        leave;
    logic        accept;
    logic [31:0] load_src;
    logic [31:0] load_ext;
    logic [31:0] final_result;
    logic        fwd_we;
    logic        unused_bus_bits;

    assign in_bus          = to_mem_bus_t'(mem_bus.to_MEM_data);
    assign data_ok         = mem_bus.data_sram_data_ok;
    assign unused_bus_bits = ^{bus_q.pc, bus_q.mem_req};

    mem_load_ext u_load_ext (
        .rdata    (load_src),
        .addr     (bus_q.alu_result[1:0]),
        .mem_op   (bus_q.mem_op),
        .ext_data (load_ext)
    );

    // In WAIT the response feeds straight through so a load retires in its data_ok cycle
    always_comb begin
        ready_go     = (state_q != S_WAIT) || data_ok;
        allow_in     = !valid_q || (ready_go && mem_bus.WB_allow_in);
        leave        = valid_q && ready_go && mem_bus.WB_allow_in;
        accept       = mem_bus.EX_to_MEM_valid && allow_in;
        load_src     = (state_q == S_HAVE) ? rdata_buf_q : mem_bus.data_sram_rdata;
        final_result = bus_q.res_from_mem ? load_ext : bus_q.alu_result;
        fwd_we       = valid_q && bus_q.gr_we && (bus_q.dest != 5'd0);
    end

    always_comb begin
        valid_d     = allow_in ? mem_bus.EX_to_MEM_valid : valid_q;
        bus_d       = bus_q;
        rdata_buf_d = rdata_buf_q;
        state_d     = state_q;

        case (state_q)
            S_WAIT: begin
                if (data_ok) begin
                    rdata_buf_d = mem_bus.data_sram_rdata;
                    state_d     = leave ? S_IDLE : S_HAVE;
                end
            end
            S_HAVE: begin
                if (leave) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new entry overrides whatever the departing instruction left behind
        if (accept) begin
            bus_d       = in_bus;
            rdata_buf_d = 32'd0;
            state_d     = in_bus.mem_req ? S_WAIT : S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q     <= 1'b0;
            state_q     <= S_IDLE;
            bus_q       <= '0;
            rdata_buf_q <= 32'd0;
        end else begin
            valid_q     <= valid_d;
            state_q     <= state_d;
            bus_q       <= bus_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    assign mem_bus.MEM_allow_in    = allow_in;
    assign mem_bus.MEM_to_WB_valid = valid_q && ready_go;
    assign mem_bus.to_WB_data      = {27'd0, bus_q.dest, final_result, bus_q.gr_we};
    assign mem_bus.MEM_fwd         = {fwd_we, bus_q.dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change on the falling edge and outputs
// are checked 1 ns later, with expected values worked out by hand.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk;
    logic resetn;
    int   vectors;
    int   miscompares;

    mem_stage_if mif ();

    mem_stage dut (
        .clk     (clk),
        .resetn  (resetn),
        .mem_bus (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [74:0] mkBus(input logic [31:0] pc, input logic [4:0] dest,
                                          input logic [31:0] alu, input logic gr_we,
                                          input logic rfm, input logic [2:0] op,
                                          input logic req);
        return {pc, dest, alu, gr_we, rfm, op, req};
    endfunction

    task automatic applyStimulus(input logic rn, input logic ex_valid, input logic [74:0] data,
                                 input logic wb_allow, input logic ok, input logic [31:0] rdata);
        @(negedge clk);
        resetn                = rn;
        mif.EX_to_MEM_valid   = ex_valid;
        mif.to_MEM_data       = data;
        mif.WB_allow_in       = wb_allow;
        mif.data_sram_data_ok = ok;
        mif.data_sram_rdata   = rdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [74:0] observed,
                               input logic [74:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("rst_valid", 75'(mif.MEM_to_WB_valid), 75'd0);
        checkOutput("rst_fwd_we", 75'(mif.MEM_fwd[37]), 75'd0);
        checkOutput("rst_allow_in", 75'(mif.MEM_allow_in), 75'd1);
        checkOutput("rst_state", 75'(dut.state_q), 75'(S_IDLE));

        // ALU instruction, dest=5
        applyStimulus(1'b1, 1'b1, mkBus(32'h1c00_0000, 5'd5, 32'h1234_5678, 1'b1, 1'b0, LD_W, 1'b0),
                      1'b1, 1'b0, 32'd0);
        checkOutput("alu_allow_empty", 75'(mif.MEM_allow_in), 75'd1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("alu_valid", 75'(mif.MEM_to_WB_valid), 75'd1);
        checkOutput("alu_wb_data", 75'(mif.to_WB_data), 75'({32'd5, 32'h1234_5678, 1'b1}));
        checkOutput("alu_fwd", 75'(mif.MEM_fwd), 75'({1'b1, 5'd5, 32'h1234_5678}));
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("alu_drained", 75'(mif.MEM_to_WB_valid), 75'd0);

        // ALU instruction writing r0: no forwarding, gr_we still carried
        applyStimulus(1'b1, 1'b1, mkBus(32'h1c00_0004, 5'd0, 32'h0000_00AA, 1'b1, 1'b0, LD_W, 1'b0),
                      1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("r0_fwd_we", 75'(mif.MEM_fwd[37]), 75'd0);
        checkOutput("r0_wb_data", 75'(mif.to_WB_data), 75'({32'd0, 32'h0000_00AA, 1'b1}));

        // LD_B lane 3, response one cycle after accept
        applyStimulus(1'b1, 1'b1, mkBus(32'h1c00_0008, 5'd7, 32'h0000_1003, 1'b1, 1'b1, LD_B, 1'b1),
                      1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'h5555_5555);
        checkOutput("ldb_wait_valid", 75'(mif.MEM_to_WB_valid), 75'd0);
        checkOutput("ldb_wait_allow", 75'(mif.MEM_allow_in), 75'd0);
        checkOutput("ldb_wait_state", 75'(dut.state_q), 75'(S_WAIT));
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h80FF_0000);
        checkOutput("ldb_ok_valid", 75'(mif.MEM_to_WB_valid), 75'd1);
        checkOutput("ldb_result", 75'(mif.to_WB_data[32:1]), 75'(32'hFFFF_FF80));
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("ldb_after_valid", 75'(mif.MEM_to_WB_valid), 75'd0);

        // LD_HU lane 2 with write-back stalled, then leave and accept together
        applyStimulus(1'b1, 1'b1, mkBus(32'h1c00_000c, 5'd8, 32'h0000_2002, 1'b1, 1'b1, LD_HU, 1'b1),
                      1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'hBEEF_1234);
        checkOutput("ldhu_ok_result", 75'(mif.to_WB_data[32:1]), 75'(32'h0000_BEEF));
        checkOutput("ldhu_ok_allow", 75'(mif.MEM_allow_in), 75'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 32'h1111_2222);
            checkOutput("ldhu_hold_state", 75'(dut.state_q), 75'(S_HAVE));
            checkOutput("ldhu_hold_valid", 75'(mif.MEM_to_WB_valid), 75'd1);
            checkOutput("ldhu_hold_result", 75'(mif.to_WB_data[32:1]), 75'(32'h0000_BEEF));
        end
        applyStimulus(1'b1, 1'b1, mkBus(32'h1c00_0010, 5'd9, 32'hCAFE_0001, 1'b1, 1'b0, LD_W, 1'b0),
                      1'b1, 1'b0, 32'h3333_4444);
        checkOutput("ldhu_release_allow", 75'(mif.MEM_allow_in), 75'd1);
        checkOutput("ldhu_release_result", 75'(mif.to_WB_data[32:1]), 75'(32'h0000_BEEF));
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("swap_state", 75'(dut.state_q), 75'(S_IDLE));
        checkOutput("swap_buf_cleared", 75'(dut.rdata_buf_q), 75'd0);
        checkOutput("swap_wb_data", 75'(mif.to_WB_data), 75'({32'd9, 32'hCAFE_0001, 1'b1}));

        // Back-to-back loads with a response every cycle
        applyStimulus(1'b1, 1'b1, mkBus(32'h1c00_0020, 5'd10, 32'h0000_3000, 1'b1, 1'b1, LD_W, 1'b1),
                      1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, mkBus(32'h1c00_0024, 5'd11, 32'h0000_3002, 1'b1, 1'b1, LD_H, 1'b1),
                      1'b1, 1'b1, 32'hDEAD_BEEF);
        checkOutput("b2b_1_valid", 75'(mif.MEM_to_WB_valid), 75'd1);
        checkOutput("b2b_1_allow", 75'(mif.MEM_allow_in), 75'd1);
        checkOutput("b2b_1_result", 75'(mif.to_WB_data[32:1]), 75'(32'hDEAD_BEEF));
        applyStimulus(1'b1, 1'b1, mkBus(32'h1c00_0028, 5'd12, 32'h0000_3001, 1'b1, 1'b1, LD_BU, 1'b1),
                      1'b1, 1'b1, 32'h8001_7FFF);
        checkOutput("b2b_2_valid", 75'(mif.MEM_to_WB_valid), 75'd1);
        checkOutput("b2b_2_result", 75'(mif.to_WB_data[32:1]), 75'(32'hFFFF_8001));
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h1234_ABCD);
        checkOutput("b2b_3_valid", 75'(mif.MEM_to_WB_valid), 75'd1);
        checkOutput("b2b_3_fwd", 75'(mif.MEM_fwd), 75'({1'b1, 5'd12, 32'h0000_00AB}));
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("b2b_drained", 75'(mif.MEM_to_WB_valid), 75'd0);

        // Store waits for its response; result is the address
        applyStimulus(1'b1, 1'b1, mkBus(32'h1c00_0030, 5'd0, 32'h0000_4004, 1'b0, 1'b0, LD_W, 1'b1),
                      1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("st_wait_valid", 75'(mif.MEM_to_WB_valid), 75'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        checkOutput("st_ok_wb_data", 75'(mif.to_WB_data), 75'({32'd0, 32'h0000_4004, 1'b0}));
        checkOutput("st_ok_valid", 75'(mif.MEM_to_WB_valid), 75'd1);

        // Reset while waiting; the late response must be dropped
        applyStimulus(1'b1, 1'b1, mkBus(32'h1c00_0040, 5'd13, 32'h0000_5000, 1'b1, 1'b1, LD_W, 1'b1),
                      1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("rstwait_pre_state", 75'(dut.state_q), 75'(S_WAIT));
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("rstwait_state", 75'(dut.state_q), 75'(S_IDLE));
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h7777_7777);
        checkOutput("rstwait_ok_valid", 75'(mif.MEM_to_WB_valid), 75'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("rstwait_after_state", 75'(dut.state_q), 75'(S_IDLE));
        checkOutput("rstwait_after_valid", 75'(mif.MEM_to_WB_valid), 75'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
